// File: rtl/axi4_lite_read_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Axi4LiteReadMasterGlobalPkg: response/protection/state encodings and       |
// | default widths shared by the AXI4-Lite read master.     Revision: 1.0      |
// +----------------------------------------------------------------------------+
package Axi4LiteReadMasterGlobalPkg;

  localparam int c_DEFAULT_ADDRESS_WIDTH   = 32;
  localparam int c_DEFAULT_DATA_WIDTH      = 32;
  localparam int c_DEFAULT_DELAY_WIDTH     = 5;
  localparam int c_DEFAULT_MAX_WAIT_CYCLES = 256;

  typedef enum logic [1:0] {
    READ_OKAY   = 2'b00,
    READ_EXOKAY = 2'b01,
    READ_SLVERR = 2'b10,
    READ_DECERR = 2'b11
  } rrespEnum;

  // Bit 0 privileged, bit 1 non-secure, bit 2 instruction.
  typedef enum logic [2:0] {
    ARPROT_DATA_SEC_UNPRIV   = 3'b000,
    ARPROT_DATA_SEC_PRIV     = 3'b001,
    ARPROT_DATA_NSEC_UNPRIV  = 3'b010,
    ARPROT_DATA_NSEC_PRIV    = 3'b011,
    ARPROT_INSTR_SEC_UNPRIV  = 3'b100,
    ARPROT_INSTR_SEC_PRIV    = 3'b101,
    ARPROT_INSTR_NSEC_UNPRIV = 3'b110,
    ARPROT_INSTR_NSEC_PRIV   = 3'b111
  } arprotEnum;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AR_SEND = 3'd1,
    ST_R_WAIT  = 3'd2,
    ST_RSP     = 3'd3,
    ST_DRAIN   = 3'd4
  } masterStateEnum;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_read_master_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_read_master_wait_timer: RREADY delay down-counter plus a         |
// | saturating RVALID wait counter with timeout flag.       Revision: 1.0      |
// +----------------------------------------------------------------------------+
module axi4_lite_read_master_wait_timer
  import Axi4LiteReadMasterGlobalPkg::*;
#(
  parameter int DELAY_WIDTH     = c_DEFAULT_DELAY_WIDTH,
  parameter int MAX_WAIT_CYCLES = c_DEFAULT_MAX_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [DELAY_WIDTH-1:0] i_delay,
  input  logic                   i_run,
  output logic                   o_delay_zero,
  output logic                   o_timeout
);

  localparam int c_WAIT_WIDTH = $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [c_WAIT_WIDTH-1:0] c_WAIT_LIMIT = c_WAIT_WIDTH'(MAX_WAIT_CYCLES);

  logic [DELAY_WIDTH-1:0]  r_delay;
  logic [c_WAIT_WIDTH-1:0] r_wait;

  // Both counters hold at their end values, so a long stall never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay <= '0;
      r_wait  <= '0;
    end else if (i_load) begin
      r_delay <= i_delay;
      r_wait  <= '0;
    end else if (i_run) begin
      if (r_delay != '0)
        r_delay <= r_delay - DELAY_WIDTH'(1);
      if (r_wait != c_WAIT_LIMIT)
        r_wait <= r_wait + c_WAIT_WIDTH'(1);
    end
  end

  assign o_delay_zero = (r_delay == '0);
  assign o_timeout    = (r_wait == c_WAIT_LIMIT);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_read_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_read_master: single-outstanding AXI4-Lite read initiator with    |
// | address window, RREADY delay and RVALID timeout.        Revision: 1.0      |
// +----------------------------------------------------------------------------+
module axi4_lite_read_master
  import Axi4LiteReadMasterGlobalPkg::*;
#(
  parameter int                       ADDRESS_WIDTH   = c_DEFAULT_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH      = c_DEFAULT_DATA_WIDTH,
  parameter int                       DELAY_WIDTH     = c_DEFAULT_DELAY_WIDTH,
  parameter int                       MAX_WAIT_CYCLES = c_DEFAULT_MAX_WAIT_CYCLES,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS     = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS     = '1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [2:0]               req_prot,
  input  logic [DELAY_WIDTH-1:0]   req_rready_delay,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_timeout,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  masterStateEnum r_state, w_next_state;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [2:0]               r_prot;
  logic [DELAY_WIDTH-1:0]   r_delay_val;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic [1:0]               r_rsp_resp;
  logic                     r_rsp_timeout;
  logic                     r_drain_pending;

  logic w_ar_hs, w_r_hs, w_delay_zero, w_timeout;
  logic w_below_min, w_above_max, w_in_window;
  logic [ADDRESS_WIDTH-1:0] w_lo_unused, w_hi_unused;

  // Window check via borrow bits so a full-range window stays lint-clean.
  assign {w_below_min, w_lo_unused} = {1'b0, req_addr} - {1'b0, MIN_ADDRESS};
  assign {w_above_max, w_hi_unused} = {1'b0, MAX_ADDRESS} - {1'b0, req_addr};
  assign w_in_window = !w_below_min && !w_above_max;

  assign w_ar_hs = (r_state == ST_AR_SEND) && arready;
  assign w_r_hs  = (r_state == ST_R_WAIT) && rvalid && w_delay_zero;

  axi4_lite_read_master_wait_timer #(
    .DELAY_WIDTH     (DELAY_WIDTH),
    .MAX_WAIT_CYCLES (MAX_WAIT_CYCLES)
  ) u_wait_timer (
    .clk          (aclk),
    .rst          (areset),
    .i_load       (w_ar_hs),
    .i_delay      (r_delay_val),
    .i_run        (r_state == ST_R_WAIT),
    .o_delay_zero (w_delay_zero),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // A handshake in the timeout cycle takes priority over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (req_valid) w_next_state = w_in_window ? ST_AR_SEND : ST_RSP;
      ST_AR_SEND: if (arready) w_next_state = ST_R_WAIT;
      ST_R_WAIT:  if (w_r_hs || w_timeout) w_next_state = ST_RSP;
      ST_RSP:     if (rsp_ready) w_next_state = r_drain_pending ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:   if (rvalid) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE:    req_ready = !areset;
      ST_AR_SEND: arvalid   = 1'b1;
      ST_R_WAIT:  rready    = w_delay_zero;
      ST_RSP:     rsp_valid = 1'b1;
      ST_DRAIN:   rready    = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr          <= '0;
      r_prot          <= '0;
      r_delay_val     <= '0;
      r_rsp_data      <= '0;
      r_rsp_resp      <= READ_OKAY;
      r_rsp_timeout   <= 1'b0;
      r_drain_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr          <= req_addr;
            r_prot          <= req_prot;
            r_delay_val     <= req_rready_delay;
            r_rsp_data      <= '0;
            r_rsp_resp      <= READ_DECERR;
            r_rsp_timeout   <= 1'b0;
            r_drain_pending <= 1'b0;
          end
        end
        ST_R_WAIT: begin
          if (w_r_hs) begin
            r_rsp_data      <= rdata;
            r_rsp_resp      <= rresp;
            r_rsp_timeout   <= 1'b0;
            r_drain_pending <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data      <= '0;
            r_rsp_resp      <= READ_SLVERR;
            r_rsp_timeout   <= 1'b1;
            r_drain_pending <= 1'b1;
          end
        end
        ST_DRAIN: if (rvalid) r_drain_pending <= 1'b0;
        default: ;
      endcase
    end
  end

  assign araddr      = r_addr;
  assign arprot      = r_prot;
  assign rsp_data    = r_rsp_data;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi4_lite_read_master: directed scenarios for the AXI4-Lite read        |
// | master with hand-computed expectations.                 Revision: 1.0      |
// +----------------------------------------------------------------------------+
module tb_axi4_lite_read_master;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int DLW  = 5;
  localparam int MAXW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_prot = '0;
  logic [DLW-1:0] req_rready_delay = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rvalid = 1'b0;
  logic          rready;

  int n_checks = 0;
  int n_pass   = 0;

  axi4_lite_read_master #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .DELAY_WIDTH     (DLW),
    .MAX_WAIT_CYCLES (MAXW),
    .MIN_ADDRESS     (32'h0000_0010),
    .MAX_ADDRESS     (32'h0000_1FFF)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_prot         (req_prot),
    .req_rready_delay (req_rready_delay),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_resp         (rsp_resp),
    .rsp_timeout      (rsp_timeout),
    .araddr           (araddr),
    .arprot           (arprot),
    .arvalid          (arvalid),
    .arready          (arready),
    .rdata            (rdata),
    .rresp            (rresp),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_req(input logic [AW-1:0] addr, input logic [2:0] prot, input logic [DLW-1:0] dly);
    req_valid        = 1'b1;
    req_addr         = addr;
    req_prot         = prot;
    req_rready_delay = dly;
  endtask

  // Drives one complete read with arready high and rvalid offered from acceptance onward.
  task automatic run_read(input logic [AW-1:0] addr, input logic [DLW-1:0] dly,
                          input logic [DW-1:0] data, input logic [1:0] resp,
                          output logic [DW-1:0] g_data, output logic [1:0] g_resp,
                          output logic g_to, output bit ok);
    int n;
    ok = 1'b1;
    start_req(addr, 3'b000, dly);
    arready = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (req_ready !== 1'b1) ok = 1'b0;
    tick();
    req_valid = 1'b0;
    rvalid = 1'b1; rdata = data; rresp = resp;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
    if (rsp_valid !== 1'b1) ok = 1'b0;
    g_data = rsp_data; g_resp = rsp_resp; g_to = rsp_timeout;
    rvalid = 1'b0; arready = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(); tick();
    n_checks++; if ({req_ready, arvalid, rready, rsp_valid, rsp_timeout} !== 5'b00000)
      $display("FAIL reset_ctrl: got %b exp 00000", {req_ready, arvalid, rready, rsp_valid, rsp_timeout}); else n_pass++;
    n_checks++; if ({araddr, arprot, rsp_data, rsp_resp} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h exp all 0", araddr, arprot, rsp_data, rsp_resp); else n_pass++;
    areset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_basic();
    start_req(32'h0000_0010, 3'b010, 5'd0);
    arready = 1'b1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL basic_req_ready: got %b exp 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    n_checks++; if ({arvalid, araddr, arprot, rready} !== {1'b1, 32'h0000_0010, 3'b010, 1'b0})
      $display("FAIL basic_ar: got v=%b a=%h p=%b rr=%b exp v=1 a=00000010 p=010 rr=0", arvalid, araddr, arprot, rready); else n_pass++;
    tick();
    n_checks++; if ({arvalid, rready, rsp_valid} !== 3'b010)
      $display("FAIL basic_rready: got %b exp 010", {arvalid, rready, rsp_valid}); else n_pass++;
    tick();
    rvalid = 1'b0; arready = 1'b0;
    n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout, rready} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0})
      $display("FAIL basic_rsp: got v=%b d=%h r=%b t=%b rr=%b exp v=1 d=deadbeef r=00 t=0 rr=0", rsp_valid, rsp_data, rsp_resp, rsp_timeout, rready); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL basic_done: got %b exp 01", {rsp_valid, req_ready}); else n_pass++;
  endtask

  task automatic test_delay();
    start_req(32'h0000_1FFF, 3'b001, 5'd4);
    arready = 1'b1;
    tick();
    req_valid = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
    n_checks++; if ({arvalid, araddr} !== {1'b1, 32'h0000_1FFF})
      $display("FAIL delay_top_addr: got v=%b a=%h exp v=1 a=00001fff", arvalid, araddr); else n_pass++;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({rready, rsp_valid} !== 2'b00)
        $display("FAIL delay_hold_%0d: got %b exp 00", i, {rready, rsp_valid}); else n_pass++;
      tick();
    end
    n_checks++; if (rready !== 1'b1) $display("FAIL delay_rise: got %b exp 1", rready); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rready} !== {1'b1, 32'hCAFE_F00D, 2'b01, 1'b0})
      $display("FAIL delay_rsp: got v=%b d=%h r=%b rr=%b exp v=1 d=cafef00d r=01 rr=0", rsp_valid, rsp_data, rsp_resp, rready); else n_pass++;
    rvalid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_ar_stall();
    start_req(32'h0000_1ABC, 3'b101, 5'd0);
    arready = 1'b0;
    tick();
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_prot = 3'b000;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if ({arvalid, araddr, arprot, req_ready} !== {1'b1, 32'h0000_1ABC, 3'b101, 1'b0})
        $display("FAIL stall_%0d: got v=%b a=%h p=%b rq=%b exp v=1 a=00001abc p=101 rq=0", i, arvalid, araddr, arprot, req_ready); else n_pass++;
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
    n_checks++; if ({arvalid, rready} !== 2'b01)
      $display("FAIL stall_release: got %b exp 01", {arvalid, rready}); else n_pass++;
    tick();
    rvalid = 1'b0;
    n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout} !== {1'b1, 32'h1234_5678, 2'b10, 1'b0})
      $display("FAIL stall_rsp: got v=%b d=%h r=%b t=%b exp v=1 d=12345678 r=10 t=0", rsp_valid, rsp_data, rsp_resp, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_window();
    logic [AW-1:0] bad [2];
    bad[0] = 32'h0000_2000;
    bad[1] = 32'h0000_000F;
    for (int i = 0; i < 2; i++) begin
      start_req(bad[i], 3'b000, 5'd0);
      arready = 1'b1;
      tick();
      req_valid = 1'b0;
      n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout, arvalid} !== {1'b1, 32'h0, 2'b11, 1'b0, 1'b0})
        $display("FAIL window_%0d: got v=%b d=%h r=%b t=%b ar=%b exp v=1 d=0 r=11 t=0 ar=0", i, rsp_valid, rsp_data, rsp_resp, rsp_timeout, arvalid); else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0; arready = 1'b0;
      n_checks++; if ({rsp_valid, arvalid, req_ready} !== 3'b001)
        $display("FAIL window_done_%0d: got %b exp 001", i, {rsp_valid, arvalid, req_ready}); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    start_req(32'h0000_0100, 3'b000, 5'd0);
    arready = 1'b1; rvalid = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    arready = 1'b0;
    for (int i = 0; i <= MAXW; i++) begin
      n_checks++; if ({rsp_valid, rready} !== 2'b01)
        $display("FAIL timeout_wait_%0d: got %b exp 01", i, {rsp_valid, rready}); else n_pass++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout, rready} !== {1'b1, 32'h0, 2'b10, 1'b1, 1'b0})
        $display("FAIL timeout_rsp_%0d: got v=%b d=%h r=%b t=%b rr=%b exp v=1 d=0 r=10 t=1 rr=0", i, rsp_valid, rsp_data, rsp_resp, rsp_timeout, rready); else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    start_req(32'h0000_3000, 3'b000, 5'd0);
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if ({rready, req_ready, rsp_valid, arvalid} !== 4'b1000)
        $display("FAIL drain_%0d: got %b exp 1000", i, {rready, req_ready, rsp_valid, arvalid}); else n_pass++;
      tick();
    end
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b00;
    tick();
    rvalid = 1'b0; req_valid = 1'b0;
    n_checks++; if ({req_ready, rsp_valid, rready} !== 3'b100)
      $display("FAIL drain_done: got %b exp 100", {req_ready, rsp_valid, rready}); else n_pass++;
  endtask

  task automatic test_timeout_tie();
    start_req(32'h0000_0200, 3'b001, 5'd8);
    arready = 1'b1; rvalid = 1'b0;
    tick();
    req_valid = 1'b0;
    rvalid = 1'b1; rdata = 32'h5A5A_5A5A; rresp = 2'b00;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if ({rready, rsp_valid} !== 2'b00)
        $display("FAIL tie_hold_%0d: got %b exp 00", i, {rready, rsp_valid}); else n_pass++;
      tick();
    end
    n_checks++; if (rready !== 1'b1) $display("FAIL tie_rready: got %b exp 1", rready); else n_pass++;
    tick();
    rvalid = 1'b0;
    n_checks++; if ({rsp_valid, rsp_data, rsp_resp, rsp_timeout} !== {1'b1, 32'h5A5A_5A5A, 2'b00, 1'b0})
      $display("FAIL tie_rsp: got v=%b d=%h r=%b t=%b exp v=1 d=5a5a5a5a r=00 t=0", rsp_valid, rsp_data, rsp_resp, rsp_timeout); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if ({req_ready, rready} !== 2'b10)
      $display("FAIL tie_no_drain: got %b exp 10", {req_ready, rready}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          t;
    bit            ok;
    run_read(32'h0000_0020, 5'd1, 32'h1111_1111, 2'b00, d, r, t, ok);
    n_checks++; if ({ok, d, r, t} !== {1'b1, 32'h1111_1111, 2'b00, 1'b0})
      $display("FAIL b2b_first: got ok=%b d=%h r=%b t=%b exp ok=1 d=11111111 r=00 t=0", ok, d, r, t); else n_pass++;
    run_read(32'h0000_1FF0, 5'd2, 32'h2222_2222, 2'b01, d, r, t, ok);
    n_checks++; if ({ok, d, r, t} !== {1'b1, 32'h2222_2222, 2'b01, 1'b0})
      $display("FAIL b2b_second: got ok=%b d=%h r=%b t=%b exp ok=1 d=22222222 r=01 t=0", ok, d, r, t); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          t;
    bit            ok;
    start_req(32'h0000_0040, 3'b011, 5'd10);
    arready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    arready = 1'b0;
    tick(); tick();
    rvalid = 1'b1;
    areset = 1'b1;
    tick();
    n_checks++; if ({req_ready, arvalid, rready, rsp_valid, rsp_timeout, araddr, arprot, rsp_data, rsp_resp} !== '0)
      $display("FAIL rst_mid_outputs: got rq=%b av=%b rr=%b rv=%b a=%h d=%h exp all 0", req_ready, arvalid, rready, rsp_valid, araddr, rsp_data); else n_pass++;
    areset = 1'b0; rvalid = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_idle: got %b exp 1", req_ready); else n_pass++;
    run_read(32'h0000_0080, 5'd0, 32'hA5A5_0F0F, 2'b00, d, r, t, ok);
    n_checks++; if ({ok, d, r, t} !== {1'b1, 32'hA5A5_0F0F, 2'b00, 1'b0})
      $display("FAIL rst_mid_next: got ok=%b d=%h r=%b t=%b exp ok=1 d=a5a50f0f r=00 t=0", ok, d, r, t); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_ar_stall();
    test_window();
    test_timeout();
    test_timeout_tie();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
